// File: rtl/dram_pkg.sv
// dram_pkg: shared types for the DRAM controller's open-row tracking.
//   ROW_BITS       - widest row address an entry can hold
//   IDLE_CNT_BITS  - width of the per-entry idle counter
//   row_stat_e     - lookup classification reported to the scheduler
//   entry_state_e  - per-(bank group, bank) entry state
//   global_state_e - tracker-wide mode (normal operation / refresh)
//   entry_t        - one table entry {state, row, idle_cnt}
package dram_pkg;

  localparam int ROW_BITS      = 16;
  localparam int IDLE_CNT_BITS = 16;

  typedef enum logic [1:0] {
    ROW_IDLE     = 2'b00,
    ROW_HIT      = 2'b01,
    ROW_MISS     = 2'b10,
    ROW_CONFLICT = 2'b11
  } row_stat_e;

  typedef enum logic [1:0] {
    CLOSED = 2'b00,
    OPEN   = 2'b01,
    AGED   = 2'b10
  } entry_state_e;

  typedef enum logic {
    RUN     = 1'b0,
    REFRESH = 1'b1
  } global_state_e;

  typedef struct packed {
    entry_state_e               state;
    logic [ROW_BITS-1:0]        row;
    logic [IDLE_CNT_BITS-1:0]   idle_cnt;
  } entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin picker with a held grant.
//   clk, rst    - clock, asynchronous active-high reset
//   req[N]      - request vector
//   flush       - drop any outstanding grant (pointer unchanged)
//   advance     - consume the outstanding grant; pointer moves past it
//   gnt_valid   - a grant is outstanding
//   gnt_idx     - index of the granted requester
// Once issued, a grant stays put regardless of req until advance or
// flush. A new grant is only picked in a cycle with no grant outstanding,
// so after an advance the next grant appears one cycle later at the
// earliest.
module rr_arbiter #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             flush,
  input  logic             advance,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               cand;

  always_comb begin
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    ptr_d       = ptr_q;
    found       = 1'b0;
    cand        = 0;
    if (flush) begin
      gnt_valid_d = 1'b0;
    end else if (gnt_valid_q) begin
      if (advance) begin
        gnt_valid_d = 1'b0;
        ptr_d       = IDX_W'((int'(gnt_idx_q) + 1) % N);
      end
    end else begin
      // Search starts at the pointer and wraps; first hit wins.
      for (int i = 0; i < N; i++) begin
        cand = (int'(ptr_q) + i) % N;
        if (!found && req[cand]) begin
          found       = 1'b1;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = IDX_W'(cand);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;

endmodule

// File: rtl/row_open_tracker.sv
// row_open_tracker: open-row table, one entry per (bank group, bank).
// Classifies each request as HIT / MISS / CONFLICT against the open row,
// auto-closes rows left idle for IDLE_CLOSE cycles, and force-closes
// everything while refresh is high.
// Ports:
//   CLK, RST                    - clock, asynchronous active-high reset
//   req_en, bank_group, bank,
//   row                         - lookup request
//   row_resolve                 - ACT/PRE issued for the pending request
//   refresh                     - level, high for the whole refresh window
//   row_stat, row_conflict      - lookup result, valid one cycle after req_en
//   all_row_closed              - no entry open (lags the table by 1 cycle)
//   close_valid, close_bg,
//   close_bank, close_ack       - auto-close offer; close_valid/close_ack
//                                 is a valid/ack pair: the offer is held
//                                 stable until close_ack is sampled with
//                                 close_valid high; only refresh withdraws
//                                 it; close_ack without close_valid is
//                                 ignored.
// ROW_BITS must not exceed dram_pkg::ROW_BITS and IDLE_CLOSE must fit in
// dram_pkg::IDLE_CNT_BITS.
module row_open_tracker
  import dram_pkg::*;
#(
  parameter int BG_COUNT   = 4,
  parameter int BANK_COUNT = 4,
  parameter int ROW_BITS   = dram_pkg::ROW_BITS,
  parameter int IDLE_CLOSE = 64,
  localparam int BG_W      = (BG_COUNT > 1) ? $clog2(BG_COUNT) : 1,
  localparam int BK_W      = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_en,
  input  logic [BG_W-1:0]     bank_group,
  input  logic [BK_W-1:0]     bank,
  input  logic [ROW_BITS-1:0] row,
  input  logic                row_resolve,
  input  logic                refresh,
  output logic [1:0]          row_stat,
  output logic [ROW_BITS-1:0] row_conflict,
  output logic                all_row_closed,
  output logic                close_valid,
  output logic [BG_W-1:0]     close_bg,
  output logic [BK_W-1:0]     close_bank,
  input  logic                close_ack
);

  localparam int N     = BG_COUNT * BANK_COUNT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PRB   = dram_pkg::ROW_BITS;
  localparam logic [IDLE_CNT_BITS-1:0] IDLE_LIM = IDLE_CNT_BITS'(IDLE_CLOSE);
  localparam entry_t ENTRY_CLOSED = '{state: CLOSED, row: '0, idle_cnt: '0};

  function automatic logic [IDX_W-1:0] idx_of(input logic [BG_W-1:0] bg,
                                               input logic [BK_W-1:0] bk);
    int i;
    i = (int'(bg) % BG_COUNT) * BANK_COUNT + (int'(bk) % BANK_COUNT);
    return IDX_W'(i);
  endfunction

  global_state_e        gstate_q, gstate_d;
  entry_t               tbl_q [N];
  entry_t               tbl_d [N];
  logic                 pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]     pend_idx_q, pend_idx_d;
  logic [PRB-1:0]       pend_row_q, pend_row_d;
  row_stat_e            pend_stat_q, pend_stat_d;
  row_stat_e            stat_q, stat_d;
  logic [ROW_BITS-1:0]  conf_q, conf_d;
  logic                 all_closed_q, all_closed_d;

  logic                 active;
  logic [IDX_W-1:0]     req_idx;
  logic [PRB-1:0]       req_row;
  entry_t               look;
  logic [N-1:0]         aged_vec;
  logic                 gnt_valid;
  logic [IDX_W-1:0]     gnt_idx;

  // Table, pending and lookup are evaluated only in RUN with refresh low;
  // the RUN cycle in which refresh rises already behaves as refresh.
  assign active  = (gstate_q == RUN) && !refresh;
  assign req_idx = idx_of(bank_group, bank);
  assign req_row = PRB'(row);

  always_comb begin
    gstate_d = gstate_q;
    case (gstate_q)
      RUN:     if (refresh)  gstate_d = REFRESH;
      REFRESH: if (!refresh) gstate_d = RUN;
      default: gstate_d = RUN;
    endcase
  end

  always_comb begin
    tbl_d        = tbl_q;
    pend_valid_d = pend_valid_q;
    pend_idx_d   = pend_idx_q;
    pend_row_d   = pend_row_q;
    pend_stat_d  = pend_stat_q;
    stat_d       = ROW_IDLE;
    conf_d       = '0;
    look         = ENTRY_CLOSED;

    if (!active) begin
      for (int i = 0; i < N; i++) tbl_d[i] = ENTRY_CLOSED;
      pend_valid_d = 1'b0;
    end else begin
      // Idle aging on the current table; hits below override it.
      if (IDLE_CLOSE != 0) begin
        for (int i = 0; i < N; i++) begin
          if (tbl_q[i].state == OPEN) begin
            tbl_d[i].idle_cnt = tbl_q[i].idle_cnt + IDLE_CNT_BITS'(1);
            if (tbl_d[i].idle_cnt == IDLE_LIM) tbl_d[i].state = AGED;
          end
        end
      end

      // Resolve first, then ack, so a same-cycle lookup sees both.
      if (row_resolve && pend_valid_q) begin
        if (pend_stat_q == ROW_MISS) begin
          tbl_d[pend_idx_q] = '{state: OPEN, row: pend_row_q, idle_cnt: '0};
        end else begin
          tbl_d[pend_idx_q] = ENTRY_CLOSED;
        end
        pend_valid_d = 1'b0;
      end

      if (close_ack && gnt_valid) tbl_d[gnt_idx] = ENTRY_CLOSED;

      if (req_en) begin
        look         = tbl_d[req_idx];
        pend_valid_d = 1'b0;
        if (look.state == CLOSED) begin
          stat_d       = ROW_MISS;
          pend_valid_d = 1'b1;
          pend_idx_d   = req_idx;
          pend_row_d   = req_row;
          pend_stat_d  = ROW_MISS;
        end else if (look.row == req_row) begin
          stat_d                  = ROW_HIT;
          tbl_d[req_idx].state    = OPEN;
          tbl_d[req_idx].idle_cnt = '0;
        end else begin
          stat_d       = ROW_CONFLICT;
          conf_d       = ROW_BITS'(look.row);
          pend_valid_d = 1'b1;
          pend_idx_d   = req_idx;
          pend_row_d   = req_row;
          pend_stat_d  = ROW_CONFLICT;
        end
      end
    end
  end

  always_comb begin
    all_closed_d = 1'b1;
    aged_vec     = '0;
    for (int i = 0; i < N; i++) begin
      if (tbl_q[i].state != CLOSED) all_closed_d = 1'b0;
      aged_vec[i] = (tbl_q[i].state == AGED);
    end
  end

  rr_arbiter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_close_arb (
    .clk       (CLK),
    .rst       (RST),
    .req       (aged_vec),
    .flush     (!active),
    .advance   (close_ack),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gstate_q     <= RUN;
      for (int i = 0; i < N; i++) tbl_q[i] <= ENTRY_CLOSED;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_row_q   <= '0;
      pend_stat_q  <= ROW_IDLE;
      stat_q       <= ROW_IDLE;
      conf_q       <= '0;
      all_closed_q <= 1'b1;
    end else begin
      gstate_q     <= gstate_d;
      for (int i = 0; i < N; i++) tbl_q[i] <= tbl_d[i];
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      pend_row_q   <= pend_row_d;
      pend_stat_q  <= pend_stat_d;
      stat_q       <= stat_d;
      conf_q       <= conf_d;
      all_closed_q <= all_closed_d;
    end
  end

  assign row_stat       = stat_q;
  assign row_conflict   = conf_q;
  assign all_row_closed = all_closed_q;
  assign close_valid    = gnt_valid;
  assign close_bg       = gnt_valid ? BG_W'(int'(gnt_idx) / BANK_COUNT) : '0;
  assign close_bank     = gnt_valid ? BK_W'(int'(gnt_idx) % BANK_COUNT) : '0;

endmodule

// File: tb/tb_row_open_tracker.sv
module tb_row_open_tracker;
  import dram_pkg::*;

  localparam int BG_W = 2;
  localparam int BK_W = 2;
  localparam int RB   = 16;

  logic            CLK, RST;
  logic            req_en;
  logic [BG_W-1:0] bank_group;
  logic [BK_W-1:0] bank;
  logic [RB-1:0]   row;
  logic            row_resolve, refresh, close_ack;
  logic [1:0]      row_stat;
  logic [RB-1:0]   row_conflict;
  logic            all_row_closed, close_valid;
  logic [BG_W-1:0] close_bg;
  logic [BK_W-1:0] close_bank;

  int n_checks = 0;
  int n_fail   = 0;

  row_open_tracker #(
    .BG_COUNT   (4),
    .BANK_COUNT (4),
    .ROW_BITS   (RB),
    .IDLE_CLOSE (8)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .req_en         (req_en),
    .bank_group     (bank_group),
    .bank           (bank),
    .row            (row),
    .row_resolve    (row_resolve),
    .refresh        (refresh),
    .row_stat       (row_stat),
    .row_conflict   (row_conflict),
    .all_row_closed (all_row_closed),
    .close_valid    (close_valid),
    .close_bg       (close_bg),
    .close_bank     (close_bank),
    .close_ack      (close_ack)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  task automatic do_req(input int bg, input int bk, input int r);
    req_en     = 1'b1;
    bank_group = BG_W'(bg);
    bank       = BK_W'(bk);
    row        = RB'(r);
    cyc();
    req_en     = 1'b0;
  endtask

  task automatic resolve();
    row_resolve = 1'b1;
    cyc();
    row_resolve = 1'b0;
  endtask

  task automatic open_bank(input int bg, input int bk, input int r);
    do_req(bg, bk, r);
    resolve();
  endtask

  task automatic wait_offer(input string tag, input int max_cyc);
    int k;
    k = 0;
    while (close_valid !== 1'b1 && k < max_cyc) begin
      cyc();
      k++;
    end
    check(tag, {31'd0, close_valid}, 32'd1);
  endtask

  initial begin
    RST = 1'b1; req_en = 1'b0; bank_group = '0; bank = '0; row = '0;
    row_resolve = 1'b0; refresh = 1'b0; close_ack = 1'b0;

    // reset values
    do_reset();
    check("rst_row_stat", row_stat, ROW_IDLE);
    check("rst_row_conflict", row_conflict, 0);
    check("rst_all_closed", all_row_closed, 1);
    check("rst_close_valid", close_valid, 0);
    check("rst_close_bg", close_bg, 0);
    check("rst_close_bank", close_bank, 0);

    // miss then hit
    do_req(1, 2, 'h1A3);
    check("t1_miss", row_stat, ROW_MISS);
    resolve();
    check("t1_stat_idle_after", row_stat, ROW_IDLE);
    do_req(1, 2, 'h1A3);
    check("t1_hit", row_stat, ROW_HIT);
    check("t1_hit_conflict_row", row_conflict, 0);
    check("t1_all_closed", all_row_closed, 0);

    // conflict then close
    do_reset();
    open_bank(0, 0, 'h10);
    do_req(0, 0, 'h20);
    check("t2_conflict", row_stat, ROW_CONFLICT);
    check("t2_conflict_row", row_conflict, 'h10);
    resolve();
    do_req(0, 0, 'h20);
    check("t2_miss_after_pre", row_stat, ROW_MISS);
    check("t2_all_closed", all_row_closed, 1);

    // auto-close after 8 idle cycles
    do_reset();
    open_bank(2, 1, 'h55);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check($sformatf("t3_no_offer_c%0d", k), close_valid, 0);
    end
    cyc();
    check("t3_offer_c9", close_valid, 1);
    check("t3_offer_bg", close_bg, 2);
    check("t3_offer_bank", close_bank, 1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("t3_hold_valid_%0d", k), close_valid, 1);
      check($sformatf("t3_hold_bg_bk_%0d", k), {close_bg, close_bank}, {2'd2, 2'd1});
    end
    do_req(2, 1, 'h55);
    check("t3_hit_while_offered", row_stat, ROW_HIT);
    check("t3_offer_kept_on_hit", close_valid, 1);
    close_ack = 1'b1;
    cyc();
    close_ack = 1'b0;
    check("t3_offer_gone_after_ack", close_valid, 0);
    do_req(2, 1, 'h55);
    check("t3_miss_after_close", row_stat, ROW_MISS);

    // round robin, with same-cycle req on the acked bank
    do_reset();
    open_bank(0, 0, 'h1);
    open_bank(3, 3, 'h2);
    wait_offer("t4_first_offer", 20);
    check("t4_first_bg_bk", {close_bg, close_bank}, {2'd0, 2'd0});
    close_ack  = 1'b1;
    req_en     = 1'b1;
    bank_group = 2'd0;
    bank       = 2'd0;
    row        = RB'('h1);
    cyc();
    close_ack  = 1'b0;
    req_en     = 1'b0;
    check("t4_bypass_miss", row_stat, ROW_MISS);
    check("t4_gap_after_ack", close_valid, 0);
    wait_offer("t4_second_offer", 20);
    check("t4_second_bg_bk", {close_bg, close_bank}, {2'd3, 2'd3});

    // refresh mid-offer
    do_reset();
    open_bank(0, 1, 'h30);
    open_bank(1, 0, 'h31);
    open_bank(2, 3, 'h32);
    wait_offer("t5_offer", 20);
    check("t5_offer_bg_bk", {close_bg, close_bank}, {2'd0, 2'd1});
    refresh = 1'b1;
    cyc();
    check("t5_offer_dropped", close_valid, 0);
    do_req(0, 1, 'h30);
    check("t5_req_ignored", row_stat, ROW_IDLE);
    check("t5_all_closed", all_row_closed, 1);
    refresh = 1'b0;
    cyc();
    cyc();
    do_req(0, 1, 'h30);
    check("t5_miss_after_refresh", row_stat, ROW_MISS);
    check("t5_no_offer_after", close_valid, 0);

    // async reset during a pending MISS
    do_reset();
    open_bank(3, 0, 'h5);
    do_req(1, 1, 'h77);
    check("t6_pending_miss", row_stat, ROW_MISS);
    check("t6_open_before_rst", all_row_closed, 0);
    #2;
    RST = 1'b1;
    #1;
    check("t6_async_row_stat", row_stat, ROW_IDLE);
    check("t6_async_all_closed", all_row_closed, 1);
    check("t6_async_close_valid", close_valid, 0);
    check("t6_async_conflict", row_conflict, 0);
    #1;
    RST = 1'b0;
    resolve();
    do_req(1, 1, 'h77);
    check("t6_resolve_ignored", row_stat, ROW_MISS);
    check("t6_still_closed", all_row_closed, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/row_open_tracker.md
# row_open_tracker

Parametrised open-row table for the DRAM controller: one entry per (bank group, bank), classifying each incoming request as HIT, MISS or CONFLICT against the currently open row. It sits between the request queue and the command scheduler. It adds three things to the fixed 4x4 lookup: configurable geometry, idle-timeout auto-close with a valid/ack close-request handshake, and a refresh state that force-closes all rows.

## Interface
- BG_COUNT, 4: number of bank groups; power of two, ≥1.
- BANK_COUNT, 4: banks per group; power of two, ≥1.
- ROW_BITS, dram_pkg::ROW_BITS: row address width.
- IDLE_CLOSE, 64: cycles an open row may sit without a HIT before a close is requested; 0 disables auto-close.
- One clock, `CLK`; reset `RST` is asynchronous and active-high.
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- req_en  in  1  request lookup strobe.
- bank_group  in  BG_W  request bank group; BG_W = max(1, $clog2(BG_COUNT)).
- bank  in  BK_W  request bank; BK_W = max(1, $clog2(BANK_COUNT)).
- row  in  ROW_BITS  request row.
- row_resolve  in  1  scheduler issued the ACT (after MISS) or PRE (after CONFLICT) for the pending request.
- refresh  in  1  level; high for the whole refresh window.
- row_stat  out  2  00 IDLE, 01 HIT, 10 MISS, 11 CONFLICT; registered.
- row_conflict  out  ROW_BITS  open row of the target bank when row_stat = CONFLICT; 0 otherwise.
- all_row_closed  out  1  no entry open.
- close_valid  out  1  auto-close request.
- close_bg  out  BG_W  bank group to precharge.
- close_bank  out  BK_W  bank to precharge.
- close_ack  in  1  scheduler issued the PRE for the offered bank.

## Operation
- **Entry states:** CLOSED, OPEN (row, idle counter), AGED (open, counter reached IDLE_CLOSE, eligible for close).
- **Global FSM:** RUN, REFRESH.
  - RUN→REFRESH on `refresh`=1: every entry becomes CLOSED in that edge, the pending request is cleared, and close_valid drops.
  - REFRESH→RUN on `refresh`=0.
- **Lookup (RUN, req_en=1):**
  - HIT if the entry is OPEN/AGED with an equal row. The counter is cleared and AGED returns to OPEN, unless that entry is being acked this cycle.
  - MISS if the entry is CLOSED.
  - CONFLICT if the entry is open with a different row; row_conflict = stored row.
- **Pending request:** MISS and CONFLICT latch {bg, bank, row, stat} as pending. A new req_en overwrites the pending request.
- **row_resolve with pending MISS:** the entry becomes OPEN with the pending row, counter 0.
- **row_resolve with pending CONFLICT:** the entry becomes CLOSED.
- Either way, pending is cleared. row_resolve with no pending request is ignored.
- **Idle counter:** increments each RUN cycle while the entry is OPEN and not hit. It saturates at IDLE_CLOSE, reaching which makes the entry AGED.
- **Close arbitration:** a round-robin arbiter over AGED entries offers one entry on close_valid/close_bg/close_bank.
  - The offer holds stable until close_ack. Only refresh withdraws an offer.
  - A HIT on the offered entry does not withdraw it; its counter clears, and on ack the entry still closes.
- **close_ack:** the offered entry becomes CLOSED. The RR pointer advances past it. close_ack with close_valid=0 is ignored.
- **Bypass (same edge, same bank):**
  - A lookup observes the result of that cycle's row_resolve and close_ack; resolve is applied before ack.
  - Example: req to the acked bank reports MISS.
- **REFRESH:** req_en is ignored (row_stat 00), and row_resolve and close_ack are ignored.
- all_row_closed = 1 iff every entry is CLOSED (registered from the table state).

## Timing
- **Reset values:** row_stat 00, row_conflict 0, all_row_closed 1, close_valid 0, close_bg/close_bank 0. All entries CLOSED, counters 0, RR pointer 0, pending cleared, FSM RUN.
- **row_stat / row_conflict:** valid exactly 1 cycle after the req_en edge and held for one cycle; 00 otherwise.
- **Table updates** (resolve, ack, hit-clear, refresh close) take effect at the sampling edge.
- **close_valid** rises 1 cycle after an entry turns AGED, given no other offer is outstanding. After an ack, the next offer appears no earlier than the following cycle.
- **all_row_closed** lags the table by 1 cycle.
- **RST mid-operation:** everything returns to the reset values immediately (async); no offer or pending request survives.

## Structure
- **dram_pkg holds:**
  - ROW_BITS.
  - The row_stat enum: ROW_IDLE, ROW_HIT, ROW_MISS, ROW_CONFLICT.
  - The entry-state enum: CLOSED, OPEN, AGED.
  - The global-state enum: RUN, REFRESH.
  - The entry struct {state, row, idle_cnt}.
- **rr_arbiter** is the one sub-module: N = BG_COUNT*BANK_COUNT requests, grant held until advance.
- The row_open_if interface is extended with close_valid/close_bg/close_bank/close_ack and parameterised widths.

## Test plan
- **Miss then hit:** req bg1/bk2/row 0x1A3 → stat MISS. Resolve; req same → HIT, row_conflict 0, all_row_closed 0.
- **Conflict then close:**
  - Bank bg0/bk0 open at row 0x10; req row 0x20 → CONFLICT, row_conflict 0x10.
  - Resolve; req row 0x20 → MISS.
- **Auto-close, IDLE_CLOSE=8:**
  - Open bg2/bk1, then idle → close_valid at cycle 9 with bg2/bk1, held for 5 cycles without ack.
  - Ack → entry CLOSED; req → MISS.
- **Round-robin:** age bg0/bk0 and bg3/bk3 together → offers bg0/bk0, then bg3/bk3 after its ack; the same-cycle req to bg0/bk0 during the ack reports MISS.
- **Refresh mid-offer:** 3 banks open, offer pending, refresh=1.
  - Next cycle: close_valid 0, all_row_closed 1, req_en → row_stat 00.
  - After refresh=0, req → MISS.
- **Async reset during a pending MISS:** RST pulse → all outputs at reset values, same cycle; row_resolve after reset does nothing.
